// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding and load-use detection.
// Latches decoded operands/control from ID, picks the freshest value for rs/rt
// from EX/MEM or MEM/WB, and drives the ALU operands and control into EX.
module id_ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] id_rs_val,
  input  logic [31:0] id_rt_val,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_wreg,
  input  logic [2:0]  id_aluctr,
  input  logic        id_alusrc,
  input  logic        id_regwrite,
  input  logic        id_memwrite,
  input  logic        id_memtoreg,
  input  logic        hold,
  input  logic        flush,
  input  logic [4:0]  exm_wreg,
  input  logic        exm_regwrite,
  input  logic [31:0] exm_result,
  input  logic [4:0]  wb_wreg,
  input  logic        wb_regwrite,
  input  logic [31:0] wb_data,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_ctr,
  output logic [31:0] ex_store_data,
  output logic [4:0]  ex_wreg,
  output logic        ex_regwrite,
  output logic        ex_memwrite,
  output logic        ex_memtoreg,
  output logic        ex_valid,
  output logic        load_use
);

  logic [31:0] rs_val_q, rt_val_q, imm_q;
  logic [4:0]  rs_q, rt_q, wreg_q;
  logic [2:0]  aluctr_q;
  logic        alusrc_q, regwrite_q, memwrite_q, memtoreg_q, valid_q;

  logic [31:0] rs_fwd, rt_fwd;
  logic        exm_live, wb_live;

  // Pipeline register: reset/flush load an all-zero bubble, hold freezes, else capture ID.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rs_val_q   <= '0;
      rt_val_q   <= '0;
      imm_q      <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      wreg_q     <= '0;
      aluctr_q   <= '0;
      alusrc_q   <= 1'b0;
      regwrite_q <= 1'b0;
      memwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      valid_q    <= 1'b0;
    end else if (!hold) begin
      rs_val_q   <= id_rs_val;
      rt_val_q   <= id_rt_val;
      imm_q      <= id_imm;
      rs_q       <= id_rs;
      rt_q       <= id_rt;
      wreg_q     <= id_wreg;
      aluctr_q   <= id_aluctr;
      alusrc_q   <= id_alusrc;
      regwrite_q <= id_regwrite;
      memwrite_q <= id_memwrite;
      memtoreg_q <= id_memtoreg;
      valid_q    <= 1'b1;
    end
  end

  // Forwarding mux: EX/MEM is the younger result so it beats MEM/WB; r0 never forwards.
  always_comb begin
    exm_live = exm_regwrite && (exm_wreg != 5'd0);
    wb_live  = wb_regwrite && (wb_wreg != 5'd0);
    rs_fwd   = rs_val_q;
    rt_fwd   = rt_val_q;
    if (exm_live && (exm_wreg == rs_q)) begin
      rs_fwd = exm_result;
    end else if (wb_live && (wb_wreg == rs_q)) begin
      rs_fwd = wb_data;
    end
    if (exm_live && (exm_wreg == rt_q)) begin
      rt_fwd = exm_result;
    end else if (wb_live && (wb_wreg == rt_q)) begin
      rt_fwd = wb_data;
    end
  end

  // Operand and control outputs into EX.
  always_comb begin
    alu_a         = rs_fwd;
    alu_b         = alusrc_q ? imm_q : rt_fwd;
    ex_store_data = rt_fwd;
    alu_ctr       = aluctr_q;
    ex_wreg       = wreg_q;
    ex_regwrite   = regwrite_q;
    ex_memwrite   = memwrite_q;
    ex_memtoreg   = memtoreg_q;
    ex_valid      = valid_q;
  end

  // Load-use: a load in EX whose target the ID instruction reads in EX. The rt field of
  // an immediate-form non-store is a destination, not a source, so it does not count.
  always_comb begin
    load_use = 1'b0;
    if (valid_q && memtoreg_q && regwrite_q && (wreg_q != 5'd0)) begin
      if ((wreg_q == id_rs) || ((wreg_q == id_rt) && (!id_alusrc || id_memwrite))) begin
        load_use = 1'b1;
      end
    end
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register and EX-stage operand feed for the five-stage MIPS pipeline. Latches decoded operands and control from ID, resolves RAW hazards by forwarding from EX/MEM and MEM/WB, and drives the A/B operands and 3-bit ALUctr into the ALU. It also detects load-use hazards and requests a one-cycle stall.

## Interface
Parameters:
- none. Widths are fixed: 32-bit data, 5-bit register numbers, 3-bit ALUctr.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- id_rs_val, id_rt_val  in  32  register-file read data from ID
- id_imm  in  32  extended immediate from ID (zero/sign/upper handled in ID)
- id_rs, id_rt, id_wreg  in  5  source register numbers and destination register number (rd/rt already selected)
- id_aluctr  in  3  000 ADDU, 001 SUBU, 010 ORI, 011 LOAD, 100 STORE, 101 BEQ, 110 LUI
- id_alusrc, id_regwrite, id_memwrite, id_memtoreg  in  1  decoded control
- hold  in  1  keep the ID/EX register contents unchanged
- flush  in  1  load a bubble (all zeros) into ID/EX
- exm_wreg  in  5, exm_regwrite  in  1, exm_result  in  32  EX/MEM destination, write enable, ALU result
- wb_wreg  in  5, wb_regwrite  in  1, wb_data  in  32  MEM/WB destination, write enable, writeback data
- alu_a, alu_b  out  32  ALU operands (combinational from ID/EX register and forward inputs)
- alu_ctr  out  3  registered ALUctr
- ex_store_data  out  32  forwarded rt value for STORE
- ex_wreg  out  5, ex_regwrite, ex_memwrite, ex_memtoreg  out  1  registered control to EX/MEM
- ex_valid  out  1  1 = real instruction in EX, 0 = bubble
- load_use  out  1  combinational stall request to the hazard/PC logic

## Operation
- Register update priority per edge: rst, then flush, then hold, then load from ID. rst and flush both clear every register to 0; ex_valid becomes 0. Load sets ex_valid to 1.
- A bubble is all zeros: aluctr 000, wreg 0, all control 0. It must never write a register or memory.
- Forwarding for each of rs and rt, using the registered numbers:
  - If exm_regwrite=1, exm_wreg≠0 and exm_wreg equals the number, use exm_result.
  - Otherwise, if wb_regwrite=1, wb_wreg≠0 and wb_wreg equals the number, use wb_data.
  - Otherwise use the latched register value.
  - EX/MEM has priority over MEM/WB. Register 0 is never forwarded.
- alu_a = forwarded rs value.
- alu_b = latched immediate when alusrc=1, else the forwarded rt value.
- ex_store_data = forwarded rt value, independent of alusrc.
- load_use = 1 when all of the following hold:
  - ex_valid=1, ex_memtoreg=1, ex_regwrite=1, ex_wreg≠0;
  - and either ex_wreg=id_rs, or ex_wreg=id_rt with (id_alusrc=0 or id_memwrite=1).
  - Otherwise load_use = 0.
- The upstream controller responds to load_use by freezing PC and IF/ID and asserting flush. This block does not feed load_use back into itself.

## Timing
- Reset values, with rst held across an edge: every registered output is 0, ex_valid=0, alu_ctr=000. alu_a, alu_b and ex_store_data are 0 unless a forward input matches register 0, which is excluded, so they are 0.
- Latency: ID values appear on the ex_* and alu_* outputs 1 cycle after the capturing edge.
- Forwarding and load_use are purely combinational within the cycle, with no extra latency.
- hold and flush asserted in the same cycle: flush wins and a bubble is loaded.
- rst asserted mid-stream: the instruction in ID/EX is discarded at that edge, with no partial state.
- EX/MEM and MEM/WB writing the same register: the EX/MEM value is selected (it is the younger result).
- hold for N cycles: outputs are stable for N cycles. Forwarded operands may still change if the exm_* or wb_* inputs change.

## Test plan
- Reset: rst=1 for 2 cycles with random inputs -> all outputs 0 and ex_valid=0. Release rst, load ADDU rs=1 (val 5), rt=2 (val 7) -> next cycle alu_a=5, alu_b=7, alu_ctr=000, ex_valid=1.
- EX/MEM forward: EX holds rs=3; exm_regwrite=1, exm_wreg=3, exm_result=0x1234 -> alu_a=0x1234. Same case with exm_wreg=0 and rs=0 -> alu_a = latched value.
- Priority: rt=4, exm_wreg=4 (0xAAAA), wb_wreg=4 (0xBBBB), both writing, alusrc=0 -> alu_b=0xAAAA. Drop exm_regwrite -> alu_b=0xBBBB.
- Immediate/store: STORE with alusrc=1, imm=8, rt forwarded from WB as 0xDEAD -> alu_b=8, ex_store_data=0xDEAD.
- Load-use: EX holds LOAD with wreg=5; ID has ADDU rs=5 -> load_use=1. ID has ORI with rt=5, alusrc=1, memwrite=0 -> load_use=0. Assert flush on the next edge -> ex_valid=0, ex_regwrite=0.
- Hold/flush: hold=1 for 3 cycles -> outputs unchanged. hold=1 with flush=1 -> bubble loaded.
